// File: rtl/timer_countdown_bcd_if.sv
// rtl/timer_countdown_bcd_if.sv - control/status bundle of the BCD countdown timer
//
// Purpose: groups the tick input, load/start/pause/clear controls, preset
// digits and the BCD count/status outputs of timer_countdown_bcd.
// Modports:
//   master - drives tick_in, load, load_* digits, start, pause, clear;
//            observes the count digits and running/paused/zero/done.
//   slave  - the timer side (inputs and outputs reversed).
interface timer_countdown_bcd_if;
  logic       tick_in;
  logic       load;
  logic [3:0] load_min_tens;
  logic [3:0] load_min_ones;
  logic [3:0] load_sec_tens;
  logic [3:0] load_sec_ones;
  logic       start;
  logic       pause;
  logic       clear;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       paused;
  logic       zero;
  logic       done;

  modport master (
    output tick_in, load, load_min_tens, load_min_ones, load_sec_tens,
           load_sec_ones, start, pause, clear,
    input  min_tens, min_ones, sec_tens, sec_ones, running, paused, zero, done
  );

  modport slave (
    input  tick_in, load, load_min_tens, load_min_ones, load_sec_tens,
           load_sec_ones, start, pause, clear,
    output min_tens, min_ones, sec_tens, sec_ones, running, paused, zero, done
  );
endinterface

// File: rtl/timer_countdown_bcd.sv
// rtl/timer_countdown_bcd.sv - mm:ss BCD countdown timer with load/start/pause/clear control
//
// Purpose: synchronises the divider tick, turns each rising edge into a
// one-second BCD decrement while running, and flags completion with a
// one-cycle done pulse.
// Ports:
//   in_clock - system clock (rising edge)
//   reset_n  - asynchronous active-low reset
//   tmr      - timer_countdown_bcd_if.slave: tick_in, load + load_* digits,
//              start, pause, clear in; min/sec digits, running, paused,
//              zero, done out
module timer_countdown_bcd #(
  parameter logic [3:0] MAX_MIN_TENS = 4'd9
) (
  input logic                 in_clock,
  input logic                 reset_n,
  timer_countdown_bcd_if.slave tmr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADED,
    S_RUNNING,
    S_PAUSED,
    S_DONE
  } state_t;

  state_t     state, state_next;
  logic [3:0] mt, mo, st, so;
  logic [3:0] mt_next, mo_next, st_next, so_next;
  logic       done_q, done_next;

  logic       sync1, sync2, tick_d;
  logic       tick_pulse;

  // tick_in is asynchronous: two synchroniser flops, then an edge detector
  // that runs in every state so an edge seen while paused is consumed.
  always_ff @(posedge in_clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      tick_d <= 1'b0;
    end else begin
      sync1  <= tmr.tick_in;
      sync2  <= sync1;
      tick_d <= sync2;
    end
  end

  assign tick_pulse = sync2 & ~tick_d;

  logic [3:0] ld_mt, ld_mo, ld_st, ld_so;
  logic       ld_nonzero;

  assign ld_mt = (tmr.load_min_tens > MAX_MIN_TENS) ? MAX_MIN_TENS : tmr.load_min_tens;
  assign ld_mo = (tmr.load_min_ones > 4'd9) ? 4'd9 : tmr.load_min_ones;
  assign ld_st = (tmr.load_sec_tens > 4'd5) ? 4'd5 : tmr.load_sec_tens;
  assign ld_so = (tmr.load_sec_ones > 4'd9) ? 4'd9 : tmr.load_sec_ones;
  assign ld_nonzero = |{ld_mt, ld_mo, ld_st, ld_so};

  // BCD borrow chain; only used while the count is nonzero, so the
  // minutes-tens digit never underflows.
  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
  logic       borrow_so, borrow_st, borrow_mo, dec_zero;

  assign borrow_so = (so == 4'd0);
  assign borrow_st = borrow_so && (st == 4'd0);
  assign borrow_mo = borrow_st && (mo == 4'd0);
  assign dec_so    = borrow_so ? 4'd9 : so - 4'd1;
  assign dec_st    = borrow_so ? ((st == 4'd0) ? 4'd5 : st - 4'd1) : st;
  assign dec_mo    = borrow_st ? ((mo == 4'd0) ? 4'd9 : mo - 4'd1) : mo;
  assign dec_mt    = borrow_mo ? mt - 4'd1 : mt;
  assign dec_zero  = ~|{dec_mt, dec_mo, dec_st, dec_so};

  logic count_zero;
  assign count_zero = ~|{mt, mo, st, so};

  always_ff @(posedge in_clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      mt     <= 4'd0;
      mo     <= 4'd0;
      st     <= 4'd0;
      so     <= 4'd0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      mt     <= mt_next;
      mo     <= mo_next;
      st     <= st_next;
      so     <= so_next;
      done_q <= done_next;
    end
  end

  // Priority: clear > load > pause > start > tick. A cycle carrying load or
  // pause consumes any tick pulse even when the control itself is ignored.
  always_comb begin
    state_next = state;
    mt_next    = mt;
    mo_next    = mo;
    st_next    = st;
    so_next    = so;
    done_next  = 1'b0;
    if (tmr.clear) begin
      state_next = S_IDLE;
      mt_next    = 4'd0;
      mo_next    = 4'd0;
      st_next    = 4'd0;
      so_next    = 4'd0;
    end else if (tmr.load) begin
      if (state != S_RUNNING) begin
        mt_next    = ld_mt;
        mo_next    = ld_mo;
        st_next    = ld_st;
        so_next    = ld_so;
        state_next = ld_nonzero ? S_LOADED : S_IDLE;
      end
    end else if (tmr.pause) begin
      if (state == S_RUNNING) begin
        state_next = S_PAUSED;
      end
    end else if (tmr.start && (state == S_LOADED || state == S_PAUSED)) begin
      if (!count_zero) begin
        state_next = S_RUNNING;
      end
    end else if (state == S_RUNNING && tick_pulse && !count_zero) begin
      mt_next = dec_mt;
      mo_next = dec_mo;
      st_next = dec_st;
      so_next = dec_so;
      if (dec_zero) begin
        state_next = S_DONE;
        done_next  = 1'b1;
      end
    end
  end

  assign tmr.min_tens = mt;
  assign tmr.min_ones = mo;
  assign tmr.sec_tens = st;
  assign tmr.sec_ones = so;
  assign tmr.running  = (state == S_RUNNING);
  assign tmr.paused   = (state == S_PAUSED);
  assign tmr.zero     = count_zero;
  assign tmr.done     = done_q;

endmodule

// File: tb/tb_timer_countdown_bcd.sv
// tb/tb_timer_countdown_bcd.sv - self-checking bench for timer_countdown_bcd
module tb_timer_countdown_bcd;

  localparam int MAXMT = 9;
  localparam int M_IDLE = 0, M_LOADED = 1, M_RUN = 2, M_PAUSED = 3, M_DONE = 4;

  logic in_clock;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  timer_countdown_bcd_if tif ();

  timer_countdown_bcd #(.MAX_MIN_TENS(4'd9)) dut (
    .in_clock (in_clock),
    .reset_n  (reset_n),
    .tmr      (tif)
  );

  initial in_clock = 1'b0;
  always #5 in_clock = ~in_clock;

  // reference model: count kept as total seconds
  int   m_state, m_total;
  bit   m_done;
  bit   t1, t2, t3;        // tick_in value seen at the last three edges
  int   tick_half, tick_cnt;
  int   done_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_count();
    int m, s;
    m = m_total / 60;
    s = m_total % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [3:0] exp_flags();
    return {m_state == M_RUN, m_state == M_PAUSED, m_total == 0, m_done};
  endfunction

  function automatic int load_total();
    int a, b, c, d;
    a = (tif.load_min_tens > MAXMT) ? MAXMT : int'(tif.load_min_tens);
    b = (tif.load_min_ones > 9) ? 9 : int'(tif.load_min_ones);
    c = (tif.load_sec_tens > 5) ? 5 : int'(tif.load_sec_tens);
    d = (tif.load_sec_ones > 9) ? 9 : int'(tif.load_sec_ones);
    return (a * 10 + b) * 60 + c * 10 + d;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_total = 0;
    m_done  = 0;
    t1 = 0; t2 = 0; t3 = 0;
  endtask

  // a tick edge first seen at edge k acts on the count at edge k+2
  task automatic model_edge();
    bit tp;
    tp = t2 & ~t3;
    t3 = t2; t2 = t1; t1 = tif.tick_in;
    m_done = 0;
    if (tif.clear) begin
      m_state = M_IDLE;
      m_total = 0;
    end else if (tif.load) begin
      if (m_state != M_RUN) begin
        m_total = load_total();
        m_state = (m_total != 0) ? M_LOADED : M_IDLE;
      end
    end else if (tif.pause) begin
      if (m_state == M_RUN) m_state = M_PAUSED;
    end else if (tif.start && (m_state == M_LOADED || m_state == M_PAUSED)) begin
      if (m_total != 0) m_state = M_RUN;
    end else if (m_state == M_RUN && tp && m_total != 0) begin
      m_total--;
      if (m_total == 0) begin
        m_state = M_DONE;
        m_done  = 1;
      end
    end
  endtask

  // called at a negedge; returns at the next negedge after checking
  task automatic step();
    if (tick_half != 0) begin
      tick_cnt++;
      if (tick_cnt >= tick_half) begin
        tick_cnt = 0;
        tif.tick_in = ~tif.tick_in;
      end
    end
    @(posedge in_clock);
    model_edge();
    @(negedge in_clock);
    check_eq("count", {tif.min_tens, tif.min_ones, tif.sec_tens, tif.sec_ones}, exp_count());
    check_eq("flags", {tif.running, tif.paused, tif.zero, tif.done}, exp_flags());
    if (tif.done) done_seen++;
  endtask

  task automatic set_digits(input logic [15:0] d);
    {tif.load_min_tens, tif.load_min_ones, tif.load_sec_tens, tif.load_sec_ones} = d;
  endtask

  task automatic do_load(input logic [15:0] d);
    set_digits(d); tif.load = 1; step(); tif.load = 0;
  endtask
  task automatic do_start();  tif.start = 1; step(); tif.start = 0; endtask
  task automatic do_pause();  tif.pause = 1; step(); tif.pause = 0; endtask
  task automatic do_clear();  tif.clear = 1; step(); tif.clear = 0; endtask
  task automatic idle(input int n); repeat (n) step(); endtask

  task automatic async_reset();
    reset_n = 0;
    #1;
    check_eq("rst_count", {tif.min_tens, tif.min_ones, tif.sec_tens, tif.sec_ones}, 32'h0);
    check_eq("rst_flags", {tif.running, tif.paused, tif.zero, tif.done}, 32'b0010);
    model_reset();
    @(negedge in_clock);
    @(negedge in_clock);
    reset_n = 1;
  endtask

  initial begin
    reset_n = 0;
    tif.tick_in = 0; tif.load = 0; tif.start = 0; tif.pause = 0; tif.clear = 0;
    set_digits(16'h0);
    tick_half = 0; tick_cnt = 0; done_seen = 0;
    model_reset();
    @(negedge in_clock);
    #1;
    check_eq("init_flags", {tif.running, tif.paused, tif.zero, tif.done}, 32'b0010);
    @(negedge in_clock);
    reset_n = 1;

    // start from IDLE does nothing
    do_start();
    check_eq("idle_start", {tif.running, tif.zero}, 32'b01);

    // 01:05 counting down with a 20-cycle tick period
    do_load(16'h0105);
    check_eq("load_0105", {tif.min_tens, tif.min_ones, tif.sec_tens, tif.sec_ones}, 32'h0105);
    do_start();
    tick_half = 10; tick_cnt = 0;
    idle(130);
    check_eq("after_6_ticks", {tif.min_tens, tif.min_ones, tif.sec_tens, tif.sec_ones}, 32'h0059);

    // reset mid-run
    async_reset();
    tick_half = 0;

    // 00:02 to completion
    do_load(16'h0002);
    do_start();
    done_seen = 0;
    tick_half = 5; tick_cnt = 0;
    idle(40);
    check_eq("done_pulses", done_seen, 1);
    check_eq("done_state", {tif.running, tif.zero}, 32'b01);
    do_start();
    check_eq("done_start", {tif.running, tif.zero}, 32'b01);

    // pause at 00:30, ticks ignored, resume
    do_load(16'h0030);
    do_start();
    do_pause();
    tick_half = 3; tick_cnt = 0;
    idle(30);
    check_eq("paused_hold", {tif.min_tens, tif.min_ones, tif.sec_tens, tif.sec_ones}, 32'h0030);
    do_start();
    idle(12);

    // clamping, and load ignored while running
    tick_half = 0;
    do_clear();
    do_load(16'hFF7C);
    check_eq("clamp", {tif.min_tens, tif.min_ones, tif.sec_tens, tif.sec_ones}, 32'h9959);
    do_start();
    do_load(16'h0001);
    check_eq("run_load", {tif.min_tens, tif.min_ones, tif.sec_tens, tif.sec_ones}, 32'h9959);

    // start+pause in RUNNING/LOADED/PAUSED, clear with ticks running
    tick_half = 2; tick_cnt = 0;
    idle(20);
    tif.start = 1; tif.pause = 1; step(); tif.start = 0; tif.pause = 0;
    tif.start = 1; tif.pause = 1; step(); tif.start = 0; tif.pause = 0;
    check_eq("sp_paused", tif.paused, 1);
    do_load(16'h0200);
    tif.start = 1; tif.pause = 1; step(); tif.start = 0; tif.pause = 0;
    check_eq("sp_loaded", {tif.running, tif.paused}, 32'b00);
    do_start();
    idle(9);
    done_seen = 0;
    do_clear();
    check_eq("clear_nodone", done_seen, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        tick_half = $urandom_range(2, 8);
        tick_cnt = 0;
      end
      tif.clear = ($urandom_range(0, 199) < 2);
      tif.load  = ($urandom_range(0, 99) < 5);
      tif.pause = ($urandom_range(0, 99) < 4);
      tif.start = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 1) == 0)
        set_digits({8'h00, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))});
      else
        set_digits(16'($urandom));
      if ($urandom_range(0, 999) == 0) begin
        tif.load = 0; tif.start = 0; tif.pause = 0; tif.clear = 0;
        async_reset();
      end else begin
        step();
      end
    end
    tif.load = 0; tif.start = 0; tif.pause = 0; tif.clear = 0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
